seq_divider: RTL and testbench

//  Iterative signed N-bit divider: the inverse of the Booth multiplier datapath.
//  Non-restoring algorithm, one quotient bit per clock, start/done handshake.

---
 rtl/seq_divider_pkg.sv | 24 ++
 rtl/seq_divider_adder.sv | 14 +
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_divider_pkg;

    // Default operand width.
    localparam int DIV_N = 8;

    // state    | meaning
    // ST_IDLE  | waiting for start; results held
    // ST_CALC  | one non-restoring quotient bit per cycle, N cycles
    // ST_FIX   | remainder restore, sign fix-up, special cases, result load
    // ST_DONE  | one-cycle done pulse
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // Iteration counter must hold the value N itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Plain W-bit adder with carry-in; subtraction is done by the caller
// inverting b and setting cin.
module seq_divider_adder #(
    parameter int W = 9
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i + W'(cin_i);

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider, non-restoring, one quotient bit per clock.
//
// state    | meaning
// ST_IDLE  | waiting for start; results held
// ST_CALC  | shift {R,Q}, R -/+ |divisor|, quotient bit = ~R[N]
// ST_FIX   | restore negative R, apply signs and special cases
// ST_DONE  | done pulse, busy low
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    div_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N:0]    rem_q, rem_d;        // partial remainder, signed N+1 bits
    logic [N-1:0]  quo_q, quo_d;        // dividend magnitude shifting into quotient
    logic [N:0]    dsr_mag_q, dsr_mag_d;
    logic          dsr_neg_q, dsr_neg_d;
    logic [N-1:0]  dvd_q, dvd_d;        // raw dividend, needed for divide-by-zero
    logic [N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    add_a, add_b, add_sum;
    logic          add_cin;

    logic [N-1:0]  dvd_mag_in;
    logic [N:0]    dsr_ext_in, dsr_mag_in;
    logic [N:0]    rem_fix;
    logic [N-1:0]  rem_mag;

    // |dividend| fits N bits unsigned even for the most negative value;
    // |divisor| is kept at N+1 bits so that -2^(N-1) needs no special case.
    assign dvd_mag_in = dividend[N-1] ? -dividend : dividend;
    assign dsr_ext_in = {divisor[N-1], divisor};
    assign dsr_mag_in = dsr_ext_in[N] ? -dsr_ext_in : dsr_ext_in;

    seq_divider_adder #(.W(N + 1)) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (add_cin),
        .sum_o (add_sum)
    );

    assign rem_fix = rem_q[N] ? add_sum : rem_q;
    assign rem_mag = rem_fix[N-1:0];

    // Next-state, datapath and shared-adder operand selection.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_mag_d   = dsr_mag_q;
        dsr_neg_d   = dsr_neg_q;
        dvd_d       = dvd_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        // Iteration step: sign of the previous R picks subtract or add.
        add_a       = {rem_q[N-1:0], quo_q[N-1]};
        add_b       = rem_q[N] ? dsr_mag_q : ~dsr_mag_q;
        add_cin     = ~rem_q[N];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvd_d     = dividend;
                    dsr_neg_d = divisor[N-1];
                    dsr_mag_d = dsr_mag_in;
                    rem_d     = '0;
                    quo_d     = dvd_mag_in;
                    count_d   = CW'(N);
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d   = add_sum;
                quo_d   = {quo_q[N-2:0], ~add_sum[N]};
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Restore step reuses the adder: R + |divisor|.
                add_a   = rem_q;
                add_b   = dsr_mag_q;
                add_cin = 1'b0;
                if (dsr_mag_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else begin
                    // -2^(N-1) / -1 falls out naturally: magnitude wraps to itself.
                    quotient_d  = (dvd_q[N-1] ^ dsr_neg_q) ? -quo_q : quo_q;
                    remainder_d = dvd_q[N-1] ? -rem_mag : rem_mag;
                    dbz_d       = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_mag_q   <= '0;
            dsr_neg_q   <= 1'b0;
            dvd_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_mag_q   <= dsr_mag_d;
            dsr_neg_q   <= dsr_neg_d;
            dvd_q       <= dvd_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a signed arithmetic model.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_pass  = 0;
    int n_total = 0;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Signed division truncating toward zero, with the divider's special cases.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic z);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else if (ai == -128 && bi == -1) begin
            q = 8'h80;
            r = 8'h00;
            z = 1'b0;
        end else begin
            q = 8'(ai / bi);
            r = 8'(ai % bi);
            z = 1'b0;
        end
    endfunction

    // Drive start just after an edge, then count edges until done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input string tag, input bit inject);
        logic [7:0] eq;
        logic [7:0] er;
        logic       ez;
        int         lat;
        int         extra;
        ref_div(a, b, eq, er, ez);
        @(posedge clk); #1;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
            if (inject && (k == 3 || k == 9)) begin
                start    = 1'b1;
                dividend = 8'd33;
                divisor  = 8'd4;
            end
            if (k == 1) chk({tag, "_busy_on"}, 32'(busy), 32'd1);
            if (done) lat = k;
        end
        chk({tag, "_latency"}, lat, N + 2);
        chk({tag, "_quot"}, 32'(quotient), 32'(eq));
        chk({tag, "_rem"}, 32'(remainder), 32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_quot_held"}, 32'(quotient), 32'(eq));
        if (inject) begin
            extra = 0;
            for (int k = 0; k < 14; k++) begin
                @(posedge clk); #1;
                if (done || busy) extra++;
            end
            chk({tag, "_no_second_op"}, extra, 0);
            chk({tag, "_quot_kept"}, 32'(quotient), 32'(eq));
        end
    endtask

    initial begin
        int spurious;
        logic [7:0] ra;
        logic [7:0] rb;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_quot", 32'(quotient), 32'd0);
        chk("reset_rem", 32'(remainder), 32'd0);
        chk("reset_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(8'd100, 8'd7, "p100_p7", 1'b0);
        run_op(8'(-100), 8'd7, "n100_p7", 1'b0);
        run_op(8'd100, 8'(-7), "p100_n7", 1'b0);
        run_op(8'(-100), 8'(-7), "n100_n7", 1'b0);
        run_op(8'd100, 8'd0, "div_zero", 1'b0);

        // Abort an op mid-CALC; the previous divide-by-zero result must clear.
        @(posedge clk); #1;
        dividend = 8'd77;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quot", 32'(quotient), 32'd0);
        chk("midrst_rem", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done || busy) spurious++;
        end
        chk("midrst_no_done", spurious, 0);
        run_op(8'd50, 8'd5, "after_rst", 1'b0);

        run_op(8'h80, 8'hFF, "min_by_m1", 1'b0);
        run_op(8'h80, 8'h80, "min_by_min", 1'b0);
        run_op(8'd5, 8'h80, "small_by_min", 1'b0);
        run_op(8'h80, 8'd1, "min_by_1", 1'b0);
        run_op(8'd127, 8'd127, "max_by_max", 1'b0);
        run_op(8'd0, 8'(-3), "zero_by_n3", 1'b0);
        run_op(8'd100, 8'd7, "ignored_start", 1'b1);

        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = (i % 10 == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, "rand", 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
